// File: rtl/master_port_if.sv
// Request, serial address/data and status signals between a local requester, master_port and its slave.
// The master modport is the master_port view; the slave modport is the surrounding environment's view.
interface master_port_if;
    logic        start;
    logic        rw;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        slave_ready;
    logic        slave_valid;
    logic        rx_data;
    logic        master_valid;
    logic        read_en;
    logic        write_en;
    logic        master_ready;
    logic        tx_address;
    logic        tx_data;
    logic        tx_burst;
    logic [7:0]  rdata;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        input  start, rw, addr, wdata, slave_ready, slave_valid, rx_data,
        output master_valid, read_en, write_en, master_ready, tx_address, tx_data,
               tx_burst, rdata, busy, done, error
    );

    modport slave (
        output start, rw, addr, wdata, slave_ready, slave_valid, rx_data,
        input  master_valid, read_en, write_en, master_ready, tx_address, tx_data,
               tx_burst, rdata, busy, done, error
    );
endinterface

// File: rtl/master_port.sv
// Single-transfer bus master: serialises a 12-bit address (and 8-bit write data) LSB first, collects 8 read bits.
// Define MASTER_TIMEOUT_EN to abort with an error pulse after TIMEOUT_CYC consecutive waiting cycles.
module master_port #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          reset,
    master_port_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, ADDR, WAIT_RD, RDATA, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;

`ifdef MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_q, wait_d;
    logic          error_q, error_d;
    logic          waiting;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MASTER_TIMEOUT_EN
            wait_q  <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MASTER_TIMEOUT_EN
            wait_q  <= wait_d;
            error_q <= error_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        rw_d             = rw_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        bus.master_valid = 1'b0;
        bus.read_en      = 1'b0;
        bus.write_en     = 1'b0;
        bus.master_ready = 1'b0;
        bus.tx_address   = 1'b0;
        bus.tx_data      = 1'b0;
        bus.tx_burst     = 1'b0;
        bus.done         = 1'b0;
        bus.busy         = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rw_d    = bus.rw;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    state_d = REQ;
                end
            end
            REQ: begin
                bus.master_valid = 1'b1;
                bus.write_en     = rw_q;
                bus.read_en      = ~rw_q;
                if (bus.slave_ready) begin
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                bus.master_valid = 1'b1;
                bus.write_en     = rw_q;
                bus.read_en      = ~rw_q;
                bus.tx_address   = addr_q[cnt_q];
                // Write data rides alongside the first 8 address bits only.
                bus.tx_data      = (rw_q && !cnt_q[3]) ? wdata_q[cnt_q[2:0]] : 1'b0;
                if (cnt_q == 4'd11) begin
                    cnt_d   = '0;
                    state_d = rw_q ? DONE : WAIT_RD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WAIT_RD: begin
                bus.master_ready = 1'b1;
                bus.read_en      = 1'b1;
                if (bus.slave_valid) begin
                    rdata_d[0] = bus.rx_data;
                    cnt_d      = 4'd1;
                    state_d    = RDATA;
                end
            end
            RDATA: begin
                bus.master_ready = 1'b1;
                if (bus.slave_valid) begin
                    rdata_d[cnt_q[2:0]] = bus.rx_data;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef MASTER_TIMEOUT_EN
        // Only cycles spent waiting on the slave count; any progress restarts the watchdog.
        waiting = ((state_q == REQ) && !bus.slave_ready) ||
                  (((state_q == WAIT_RD) || (state_q == RDATA)) && !bus.slave_valid);
        wait_d  = waiting ? (wait_q + TW'(1)) : '0;
        error_d = 1'b0;
        if (waiting && (wait_q == TW'(TIMEOUT_CYC - 1))) begin
            state_d = IDLE;
            cnt_d   = '0;
            wait_d  = '0;
            error_d = 1'b1;
        end
`endif
    end

    assign bus.rdata = rdata_q;
`ifdef MASTER_TIMEOUT_EN
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif
endmodule

// File: tb/tb_master_port.sv
// Randomised transactions against a cycle-window model of the master_port protocol.
module tb_master_port;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    master_port_if bus();
    master_port #(.TIMEOUT_CYC(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [7:0] model_rdata = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] all_outs();
        return {bus.master_valid, bus.read_en, bus.write_en, bus.master_ready, bus.tx_address,
                bus.tx_data, bus.tx_burst, bus.busy, bus.done, bus.error, bus.rdata};
    endfunction

    // The model derives each phase window from the cycle count since start was sampled:
    // REQ 1..r_wait+1, ADDR the following 12 cycles, then read bits as slave_valid delivers them.
    task automatic run_txn(input bit wr, input logic [11:0] a, input logic [7:0] wd,
                           input logic [7:0] rd, input int r_wait, input bit rnd,
                           input int stall_len, input int exp_fixed);
        int exp_done, done_cyc, done_cnt, delivered, stall_left, idx;
        int bad_mv, bad_re, bad_we, bad_mr, bad_busy, bad_tx, bad_misc;
        bit in_req, in_addr, rd_win, idle, v;
        logic [11:0] got_a;
        logic [11:0] got_d;
        exp_done = wr ? r_wait + 14 : 0;
        done_cyc = -1; done_cnt = 0; delivered = 0; stall_left = stall_len;
        bad_mv = 0; bad_re = 0; bad_we = 0; bad_mr = 0; bad_busy = 0; bad_tx = 0; bad_misc = 0;
        got_a = '0; got_d = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.rw = wr; bus.addr = a; bus.wdata = wd;
        bus.slave_ready = 1'b0; bus.slave_valid = 1'b0; bus.rx_data = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            in_req  = (c <= r_wait + 1);
            in_addr = (c >= r_wait + 2) && (c <= r_wait + 13);
            rd_win  = !wr && (c >= r_wait + 14) && (delivered < 8);
            idle    = (exp_done != 0) && (c > exp_done);
            if (bus.master_valid !== (in_req || in_addr)) bad_mv++;
            if (bus.write_en !== (wr && (in_req || in_addr))) bad_we++;
            if (bus.read_en !== (!wr && (in_req || in_addr || (rd_win && delivered == 0)))) bad_re++;
            if (bus.master_ready !== rd_win) bad_mr++;
            if (bus.busy !== !idle) bad_busy++;
            if (bus.tx_burst !== 1'b0 || bus.error !== 1'b0) bad_misc++;
            if (in_addr) begin
                idx = c - r_wait - 2;
                got_a[idx] = bus.tx_address;
                got_d[idx] = bus.tx_data;
            end else if (bus.tx_address !== 1'b0 || bus.tx_data !== 1'b0) begin
                bad_tx++;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (idle) break;
            // Inputs for the edge closing cycle c; request fields and start are junk after launch.
            bus.start = ((exp_done == 0) || (c <= exp_done)) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.rw    = 1'($urandom_range(0, 1));
            bus.addr  = 12'($urandom);
            bus.wdata = 8'($urandom);
            bus.slave_ready = (c > r_wait);
            if (rd_win) begin
                if (delivered == 5 && stall_left > 0) begin
                    v = 1'b0;
                    stall_left--;
                end else begin
                    v = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                bus.slave_valid = v;
                bus.rx_data = v ? rd[delivered] : 1'($urandom_range(0, 1));
                if (v) begin
                    delivered++;
                    if (delivered == 8) exp_done = c + 1;
                end
            end else begin
                bus.slave_valid = 1'($urandom_range(0, 1));
                bus.rx_data     = 1'($urandom_range(0, 1));
            end
        end
        bus.start = 1'b0;
        if (!wr) model_rdata = rd;
        check("done_cycle", done_cyc, exp_done);
        if (exp_fixed > 0) check("latency", done_cyc, exp_fixed);
        check("done_pulses", done_cnt, 1);
        check("tx_address", got_a, a);
        check("tx_data", got_d, wr ? {4'h0, wd} : 12'h000);
        check("master_valid", bad_mv, 0);
        check("read_en", bad_re, 0);
        check("write_en", bad_we, 0);
        check("master_ready", bad_mr, 0);
        check("busy", bad_busy, 0);
        check("tx_idle_zero", bad_tx, 0);
        check("burst_error", bad_misc, 0);
        check("rdata", bus.rdata, model_rdata);
    endtask

    task automatic reset_mid_addr(input logic [11:0] a, input logic [7:0] wd);
        int dones;
        @(negedge clk);
        bus.start = 1'b1; bus.rw = 1'b1; bus.addr = a; bus.wdata = wd; bus.slave_ready = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.slave_ready = 1'b1;
        end
        check("pre_reset_tx_address", bus.tx_address, a[5]);
        reset = 1'b1;
        #1;
        check("reset_outputs", all_outs(), 18'h0);
        model_rdata = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        check("post_reset_quiet", dones, 0);
    endtask

`ifdef MASTER_TIMEOUT_EN
    task automatic timeout_test();
        int err_cyc, err_cnt, done_cnt;
        err_cyc = -1; err_cnt = 0; done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 12'h123; bus.slave_ready = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.error === 1'b1) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = c;
            end
            if (bus.done === 1'b1) done_cnt++;
        end
        check("timeout_cycle", err_cyc, 17);
        check("timeout_pulses", err_cnt, 1);
        check("timeout_no_done", done_cnt, 0);
        check("timeout_idle", bus.busy, 1'b0);
    endtask
`endif

    initial begin
        bit wr;
        reset = 1'b1;
        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.slave_ready = 1'b0; bus.slave_valid = 1'b0; bus.rx_data = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", all_outs(), 18'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_release", all_outs(), 18'h0);

        run_txn(1'b1, 12'hA5C, 8'h3B, 8'h00, 0, 1'b0, 0, 14);
        run_txn(1'b0, 12'h001, 8'h00, 8'hC6, 0, 1'b0, 0, 22);
        run_txn(1'b0, 12'h7E2, 8'h00, 8'h5A, 0, 1'b0, 3, 25);
        run_txn(1'b1, 12'hFFF, 8'hFF, 8'h00, 10, 1'b0, 0, 24);
        reset_mid_addr(12'h5A5, 8'hA5);
        run_txn(1'b1, 12'h000, 8'h00, 8'h00, 0, 1'b0, 0, 14);

        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            run_txn(wr, 12'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 12)), 1'b1, int'($urandom_range(0, 4)), 0);
        end

`ifdef MASTER_TIMEOUT_EN
        timeout_test();
        run_txn(1'b0, 12'h3C3, 8'h00, 8'h81, 2, 1'b0, 0, 24);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/master_port.md
MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, is the watchdog limit in clock cycles (used only when MASTER_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  local request strobe, sampled only in IDLE.
REQ-005 rw  input  1  1 = write, 0 = read; latched with start.
REQ-006 addr  input  12  target address; latched with start.
REQ-007 wdata  input  8  write data; latched with start.
REQ-008 slave_ready  input  1  slave accepts request / address phase.
REQ-009 slave_valid  input  1  slave is driving a valid read-data bit on rx_data.
REQ-010 rx_data  input  1  serial read data, LSB first.
REQ-011 master_valid, read_en, write_en  output  1 each  request qualifiers to the slave.
REQ-012 master_ready  output  1  master is ready to receive read data.
REQ-013 tx_address, tx_data  output  1 each  serial address and write data, LSB first.
REQ-014 tx_burst  output  1  held 0 (single transfers only).
REQ-015 rdata  output  8  assembled read data.
REQ-016 busy, done, error  output  1 each  transaction in progress, 1-cycle completion pulse, 1-cycle abort pulse.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, ADDR, WAIT_RD, RDATA, DONE.
REQ-018 IDLE: start=1 latches rw/addr/wdata, moves to REQ; start in any other state SHALL be ignored.
REQ-019 REQ: master_valid=1, write_en=rw, read_en=~rw; slave_ready=1 moves to ADDR with bit counter 0.
REQ-020 ADDR: 12 cycles; tx_address=addr[cnt]; tx_data=wdata[cnt] for write and cnt<8, else 0; master_valid, read_en/write_en stay asserted; at cnt=11 go to DONE (write) or WAIT_RD (read).
REQ-021 WAIT_RD: master_ready=1, read_en=1; slave_valid=1 samples rx_data into rdata[0], moves to RDATA with count 1.
REQ-022 RDATA: master_ready=1; each cycle with slave_valid=1 shifts rx_data into rdata[count] and increments; slave_valid=0 stalls without loss; after bit 7, go to DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; rdata SHALL hold its value until the next read's first sampled bit.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Latency with slave_ready/slave_valid constantly high: write done in the 14th cycle after start is sampled; read done in the 22nd.
REQ-026 All bus outputs other than those named per state SHALL be 0; tx_address/tx_data SHALL be 0 outside ADDR.

Reset
REQ-027 reset SHALL asynchronously force IDLE, counters 0, rdata 0x00, and every output 0, including mid-transaction; the next start after release begins a fresh transaction.

Configuration
REQ-028 With MASTER_TIMEOUT_EN defined, a counter SHALL run in REQ, WAIT_RD and RDATA-stall; reaching TIMEOUT_CYC consecutive waiting cycles aborts to IDLE, pulses error for one cycle, no done.
REQ-029 Without MASTER_TIMEOUT_EN, the FSM SHALL wait indefinitely and error SHALL be tied 0.

Verification
REQ-030 Write addr=0xA5C, wdata=0x3B, slave_ready high -> tx_address bits 0,0,1,1,1,0,1,0,0,1,0,1 in ADDR, tx_data 1,1,0,1,1,1,0,0,0,0,0,0, done at cycle 14.
REQ-031 Read addr=0x001, slave returns 0xC6 LSB first with slave_valid high -> rdata=0xC6, done at cycle 22, write_en never 1.
REQ-032 Read with slave_valid low for 3 cycles after bit 4 -> rdata still correct, done delayed by 3 cycles.
REQ-033 slave_ready held low 10 cycles after start -> master_valid held, ADDR starts after slave_ready rises; start pulses meanwhile ignored.
REQ-034 reset asserted during ADDR cnt=5 -> all outputs 0 immediately, busy=0, no done.
REQ-035 MASTER_TIMEOUT_EN, TIMEOUT_CYC=16, slave_ready never high -> error pulse after 16 REQ cycles, back to IDLE, done stays 0.
